// File: rtl/uart_cmd_sequencer.sv
// Command sequencer between the UART receiver and sender: decodes 'r'/'w' commands,
// owns the LED register and sends one reply per command. Optional echo: UART_CMD_ECHO_EN.
module uart_cmd_sequencer #(
  parameter int               CNT_W    = 27,
  parameter logic [CNT_W-1:0] TIMEOUT  = 27'd100000000,
  parameter logic [7:0]       ACK_BYTE = 8'h4B,
  parameter logic [7:0]       NAK_BYTE = 8'h3F
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ack,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic [7:0] LEDs,
  output logic       overrun,
  output logic       cmd_error
);

  typedef enum logic [2:0] {IDLE, WAIT_ARG, SEND, WAIT_TX, ECHO} state_t;

  localparam logic [CNT_W-1:0] TMAX = TIMEOUT - CNT_W'(1);
  localparam logic [7:0] CMD_W = 8'h77;
  localparam logic [7:0] CMD_R = 8'h72;

  state_t           state;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       reply;
  logic             tx_first;
  logic             accept;
  logic             busy_state;
  logic             dec_go;
  logic [7:0]       dec_byte;
  logic             dec_arg;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] byte_q;
  logic       is_arg;
  logic [1:0] echo_ph;
`endif

  // A level held high on rx_ready counts once: only its rising edge is an event.
  assign accept     = rx_ready & ~rdy_q;
  assign busy_state = (state == SEND) || (state == WAIT_TX) || (state == ECHO);

  // The decoder sees either the live byte or, when echoing, the byte saved for it.
  always_comb begin
    dec_go   = 1'b0;
    dec_byte = rx_data;
    dec_arg  = 1'b0;
`ifdef UART_CMD_ECHO_EN
    dec_go   = (state == ECHO) && (echo_ph == 2'd2) && !tx_busy;
    dec_byte = byte_q;
    dec_arg  = is_arg;
`else
    dec_go   = accept && ((state == IDLE) || (state == WAIT_ARG));
    dec_arg  = (state == WAIT_ARG);
`endif
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      cnt       <= '0;
      reply     <= '0;
      tx_first  <= 1'b0;
      rx_ack    <= 1'b0;
      tx_data   <= '0;
      tx_send   <= 1'b0;
      LEDs      <= '0;
      overrun   <= 1'b0;
      cmd_error <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      byte_q    <= '0;
      is_arg    <= 1'b0;
      echo_ph   <= '0;
`endif
    end else begin
      rdy_q     <= rx_ready;
      rx_ack    <= accept;
      tx_send   <= 1'b0;
      cmd_error <= 1'b0;
      if (accept && busy_state) overrun <= 1'b1;

      case (state)
        IDLE: begin
`ifdef UART_CMD_ECHO_EN
          if (accept) begin
            byte_q  <= rx_data;
            is_arg  <= 1'b0;
            echo_ph <= 2'd0;
            state   <= ECHO;
          end
`endif
        end
        WAIT_ARG: begin
          if (!accept) begin
            if (cnt == TMAX) begin
              cmd_error <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_CMD_ECHO_EN
          else begin
            byte_q  <= rx_data;
            is_arg  <= 1'b1;
            echo_ph <= 2'd0;
            state   <= ECHO;
          end
`endif
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= reply;
            tx_send  <= 1'b1;
            tx_first <= 1'b1;
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // Sender may raise busy one cycle late, so the first cycle is skipped.
          tx_first <= 1'b0;
          if (!tx_first && !tx_busy) state <= IDLE;
        end
`ifdef UART_CMD_ECHO_EN
        ECHO: begin
          case (echo_ph)
            2'd0: if (!tx_busy) begin
              tx_data <= byte_q;
              tx_send <= 1'b1;
              echo_ph <= 2'd1;
            end
            2'd1:    echo_ph <= 2'd2;
            default: ;
          endcase
        end
`endif
        default: state <= IDLE;
      endcase

      if (dec_go) begin
        if (dec_arg) begin
          LEDs  <= dec_byte;
          reply <= ACK_BYTE;
          state <= SEND;
        end else if (dec_byte == CMD_W) begin
          cnt   <= '0;
          state <= WAIT_ARG;
        end else if (dec_byte == CMD_R) begin
          reply <= LEDs;
          state <= SEND;
        end else begin
          reply     <= NAK_BYTE;
          cmd_error <= 1'b1;
          state     <= SEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: vector table, hand sequences for timing/timeout/overrun,
// and random commands checked against an LED-register/reply model.
module tb_uart_cmd_sequencer;

  typedef struct {
    logic [7:0] cmd;
    logic       has_arg;
    logic [7:0] arg;
    logic [7:0] exp_tx;
    logic [7:0] exp_led;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic [7:0] LEDs;
  logic       overrun;
  logic       cmd_error;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.TIMEOUT(27'd16)) dut (
    .Clk_100M(clk), .Reset(Reset), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .LEDs(LEDs),
    .overrun(overrun), .cmd_error(cmd_error)
  );

  // Sender model: busy for busy_len cycles starting the cycle after tx_send.
  int busy_left = 0;
  int busy_len  = 2;
  bit force_busy = 1'b0;
  assign tx_busy = force_busy || (busy_left != 0);
  always @(posedge clk) begin
    if (Reset) busy_left <= 0;
    else if (tx_send) busy_left <= busy_len;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] act_tx[$];
  int send_n = 0, err_n = 0, ack_n = 0, busy_viol = 0;
  int send_cyc = 0, err_cyc = 0, ack_cyc = 0;
  always @(negedge clk) begin
    if (tx_send) begin
      act_tx.push_back(tx_data);
      send_n   <= send_n + 1;
      send_cyc <= cyc;
      if (tx_busy) busy_viol <= busy_viol + 1;
    end
    if (cmd_error) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (rx_ack) begin
      ack_n   <= ack_n + 1;
      ack_cyc <= cyc;
    end
  end

  int total = 0, passed = 0;
  logic [7:0] model_led = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pack_tx(input int base);
    logic [31:0] r = 0;
    for (int i = base; i < act_tx.size(); i++) r = (r << 8) | 32'(act_tx[i]);
    return r | (32'(act_tx.size() - base) << 24);
  endfunction

  function automatic logic [31:0] pack_q(input logic [7:0] q[$]);
    logic [31:0] r = 0;
    foreach (q[i]) r = (r << 8) | 32'(q[i]);
    return r | (32'(q.size()) << 24);
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic h, input logic [7:0] a,
                              input logic [7:0] t, input logic [7:0] l, input logic e);
    vec_t v;
    v.cmd = c; v.has_arg = h; v.arg = a; v.exp_tx = t; v.exp_led = l; v.exp_err = e;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, output int ec);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    ec = cyc + 1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    @(negedge clk);
  endtask

  // Quiet = no send and sender idle for 4 cycles: DUT is in IDLE or WAIT_ARG.
  task automatic wait_idle();
    int q = 0;
    int n = 0;
    while (q < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (!tx_busy && !tx_send) q++;
      else q = 0;
    end
    if (q < 4) begin
      total++;
      $display("FAIL idle_wait: got busy after %0d cycles expected quiet", n);
    end
  endtask

  task automatic do_cmd(input vec_t v, input string tag);
    int tb = act_tx.size();
    int eb = err_n;
    int ab = ack_n;
    int ec;
    logic [7:0] exp_q[$];
    send_byte(v.cmd, ec);
    if (v.has_arg) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(v.arg, ec);
    end
    wait_idle();
`ifdef UART_CMD_ECHO_EN
    exp_q.push_back(v.cmd);
    if (v.has_arg) exp_q.push_back(v.arg);
`endif
    exp_q.push_back(v.exp_tx);
    chk($sformatf("%s_tx", tag), pack_tx(tb), pack_q(exp_q));
    chk($sformatf("%s_led", tag), 32'(LEDs), 32'(v.exp_led));
    chk($sformatf("%s_err", tag), 32'(err_n - eb), 32'(v.exp_err));
    chk($sformatf("%s_acks", tag), 32'(ack_n - ab), v.has_arg ? 32'd2 : 32'd1);
  endtask

  vec_t tbl[9];

  initial begin
    int ec, tb, eb, ab, n;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    vec_t v;

    tbl[0] = mk(8'h72, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[1] = mk(8'h77, 1'b1, 8'hA5, 8'h4B, 8'hA5, 1'b0);
    tbl[2] = mk(8'h41, 1'b0, 8'h00, 8'h3F, 8'hA5, 1'b1);
    tbl[3] = mk(8'h72, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b0);
    tbl[4] = mk(8'h77, 1'b1, 8'h00, 8'h4B, 8'h00, 1'b0);
    tbl[5] = mk(8'h72, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[6] = mk(8'h77, 1'b1, 8'hFF, 8'h4B, 8'hFF, 1'b0);
    tbl[7] = mk(8'h57, 1'b0, 8'h00, 8'h3F, 8'hFF, 1'b1);
    tbl[8] = mk(8'h72, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);

    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {rx_ack, tx_send, tx_data, LEDs, overrun, cmd_error}, 32'h0);

    // 'r' with idle sender: ack one cycle after the event, send two cycles after.
    busy_len = 3;
    tb = act_tx.size();
    send_byte(8'h72, ec);
    wait_idle();
    chk("r_ack_cycle", 32'(ack_cyc), 32'(ec));
    chk("r_send_cycle", 32'(send_cyc - tb * 0), 32'(ec + 1));
    exp_q = {};
`ifdef UART_CMD_ECHO_EN
    exp_q.push_back(8'h72);
`endif
    exp_q.push_back(8'h00);
    chk("r_tx", pack_tx(tb), pack_q(exp_q));

    for (int i = 0; i < 9; i++) begin
      busy_len = $urandom_range(1, 6);
      do_cmd(tbl[i], $sformatf("vec%0d", i));
    end
    model_led = 8'hFF;

    // Argument timeout: error 16 cycles into WAIT_ARG, nothing sent, LEDs kept.
    tb = act_tx.size();
    eb = err_n;
    send_byte(8'h77, ec);
    n = 0;
    while (err_n == eb && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err", 32'(err_n - eb), 32'd1);
`ifndef UART_CMD_ECHO_EN
    chk("tmo_cycle", 32'(err_cyc), 32'(ec + 16));
`endif
    wait_idle();
`ifdef UART_CMD_ECHO_EN
    chk("tmo_tx", 32'(act_tx.size() - tb), 32'd1);
`else
    chk("tmo_tx", 32'(act_tx.size() - tb), 32'd0);
`endif
    chk("tmo_led", 32'(LEDs), 32'(model_led));
    do_cmd(mk(8'h72, 1'b0, 8'h00, model_led, model_led, 1'b0), "tmo_r");

    // Random commands against the LED/reply model.
    for (int i = 0; i < 30; i++) begin
      busy_len = $urandom_range(1, 6);
      case ($urandom_range(0, 2))
        0: v = mk(8'h72, 1'b0, 8'h00, model_led, model_led, 1'b0);
        1: begin
          b = 8'($urandom);
          model_led = b;
          v = mk(8'h77, 1'b1, b, 8'h4B, model_led, 1'b0);
        end
        default: begin
          do b = 8'($urandom); while (b == 8'h77 || b == 8'h72);
          v = mk(b, 1'b0, 8'h00, 8'h3F, model_led, 1'b1);
        end
      endcase
      do_cmd(v, $sformatf("rnd%0d", i));
    end

    // Reset while waiting for an argument clears LEDs and state.
    send_byte(8'h77, ec);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    model_led = 8'h00;
    chk("rst_mid_led", 32'(LEDs), 32'h0);
    do_cmd(mk(8'h72, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0), "rst_mid_r");

    // Second byte while the reply is blocked by a busy sender: overrun, acked, dropped.
    chk("ovr_clear", 32'(overrun), 32'd0);
    force_busy = 1'b1;
    tb = act_tx.size();
    ab = ack_n;
    send_byte(8'h72, ec);
    send_byte(8'h31, ec);
    @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_acks", 32'(ack_n - ab), 32'd2);
    force_busy = 1'b0;
    wait_idle();
    exp_q = {};
`ifdef UART_CMD_ECHO_EN
    exp_q.push_back(8'h72);
`endif
    exp_q.push_back(model_led);
    chk("ovr_tx", pack_tx(tb), pack_q(exp_q));
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("send_while_busy", 32'(busy_viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
